// File: rtl/timer256_regs.sv
// Register front end for the 256 Hz real-time timer: prescaler, 8-bit counter,
// CTRL/CNT bus decode and registered one-cycle IRQ strobes at 32/8/2/1 Hz.
module timer256_regs #(
    parameter int          PRESCALE  = 128,
    parameter logic [23:0] CTRL_ADDR = 24'h2040,
    parameter logic [23:0] CNT_ADDR  = 24'h2041
) (
    input  logic        rt_clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_valid,
    output logic [7:0]  timer,
    output logic        irq_32hz,
    output logic        irq_8hz,
    output logic        irq_2hz,
    output logic        irq_1hz
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic          enable;
    logic [PW-1:0] prescaler;
    logic          ctrl_hit;
    logic          cnt_hit;
    logic          ctrl_write;
    logic          clear;
    logic          tick;
    logic          read_hit;
    logic [7:0]    timer_next;
    logic [7:0]    falls;
    logic [7:0]    read_data;

    always_comb begin
        ctrl_hit   = (bus_address_in == CTRL_ADDR);
        cnt_hit    = (bus_address_in == CNT_ADDR);
        ctrl_write = bus_write & ctrl_hit;
        clear      = ctrl_write & bus_data_in[1];
        tick       = enable & (prescaler == PRE_MAX);
        read_hit   = bus_read & (ctrl_hit | cnt_hit);
        timer_next = timer + 8'd1;
        falls      = timer & ~timer_next;
    end

    // Reads return pre-edge state, so the clear bit and a concurrent increment are never visible.
    always_comb begin
        read_data = timer;
        if (ctrl_hit) begin
            read_data = {7'b0, enable};
        end
    end

    always_ff @(posedge rt_clk) begin
        if (reset) begin
            enable         <= 1'b0;
            prescaler      <= '0;
            timer          <= 8'd0;
            bus_data_out   <= 8'd0;
            bus_data_valid <= 1'b0;
            irq_32hz       <= 1'b0;
            irq_8hz        <= 1'b0;
            irq_2hz        <= 1'b0;
            irq_1hz        <= 1'b0;
        end else begin
            if (ctrl_write) begin
                enable <= bus_data_in[0];
            end

            irq_32hz <= 1'b0;
            irq_8hz  <= 1'b0;
            irq_2hz  <= 1'b0;
            irq_1hz  <= 1'b0;
            if (clear) begin
                timer     <= 8'd0;
                prescaler <= '0;
            end else if (tick) begin
                timer     <= timer_next;
                prescaler <= '0;
                irq_32hz  <= falls[2];
                irq_8hz   <= falls[4];
                irq_2hz   <= falls[6];
                irq_1hz   <= falls[7];
            end else if (enable) begin
                prescaler <= prescaler + PW'(1);
            end

            bus_data_valid <= read_hit;
            if (read_hit) begin
                bus_data_out <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_timer256_regs.sv
// Randomized scoreboard bench for timer256_regs: reads are queued by the driver
// and checked by a negedge monitor; counter and IRQs follow an arithmetic model.
module tb_timer256_regs;

    localparam int          P    = 4;
    localparam logic [23:0] CTRL = 24'h2040;
    localparam logic [23:0] CNT  = 24'h2041;
    localparam logic [23:0] BAD  = 24'h2042;

    logic        rt_clk;
    logic        reset;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_data_valid;
    logic [7:0]  timer;
    logic        irq_32hz;
    logic        irq_8hz;
    logic        irq_2hz;
    logic        irq_1hz;

    timer256_regs #(.PRESCALE(P), .CTRL_ADDR(CTRL), .CNT_ADDR(CNT)) dut (
        .rt_clk(rt_clk),
        .reset(reset),
        .bus_write(bus_write),
        .bus_read(bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out),
        .bus_data_valid(bus_data_valid),
        .timer(timer),
        .irq_32hz(irq_32hz),
        .irq_8hz(irq_8hz),
        .irq_2hz(irq_2hz),
        .irq_1hz(irq_1hz)
    );

    initial begin
        rt_clk = 1'b0;
        forever #5 rt_clk = ~rt_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the count is simply enabled cycles since the last clear divided by P.
    int         m_en_cycles = 0;
    bit         m_enable    = 1'b0;
    int         m_timer     = 0;
    logic [3:0] m_irq       = 4'h0;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] exp_q[$];

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic checkOutput();
        check("timer", int'(timer), m_timer);
        check("irq", int'({irq_1hz, irq_2hz, irq_8hz, irq_32hz}), int'(m_irq));
    endtask

    task automatic applyStimulus(input bit rst, input bit w, input bit r,
                                 input logic [23:0] a, input logic [7:0] d);
        int old_t;
        bit ticked;
        reset = rst; bus_write = w; bus_read = r;
        bus_address_in = a; bus_data_in = d;
        @(posedge rt_clk);
        old_t  = m_timer;
        ticked = 1'b0;
        if (rst) begin
            m_en_cycles = 0; m_enable = 1'b0; m_timer = 0; m_irq = 4'h0; m_hold = 8'h00;
        end else begin
            if (r && (a == CTRL || a == CNT))
                exp_q.push_back((a == CTRL) ? {7'b0, m_enable} : old_t[7:0]);
            if (m_enable) begin
                m_en_cycles++;
                ticked = (m_en_cycles % P == 0);
            end
            m_timer = (m_en_cycles / P) % 256;
            m_irq   = 4'h0;
            if (w && a == CTRL && d[1]) begin
                m_en_cycles = 0;
                m_timer     = 0;
            end else if (ticked) begin
                m_irq = {m_timer == 0, m_timer % 128 == 0, m_timer % 32 == 0, m_timer % 8 == 0};
            end
            if (w && a == CTRL) m_enable = d[0];
        end
        #1;
        reset = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 24'h0, 8'h0);
    endtask

    // Advance until the next edge will increment the counter away from 'target'.
    task automatic waitTick(input int target);
        int budget;
        budget = 2000;
        while (!(m_enable && ((m_en_cycles + 1) % P == 0) && m_timer == target) && budget > 0) begin
            idle(1);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            $display("[TB] FAIL wait_tick: timeout waiting for 0x%0h, model at 0x%0h", target, m_timer);
        end
    endtask

    // Monitor: every decoded read must surface exactly one cycle after its strobe.
    always @(negedge rt_clk) begin
        if (bus_data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                m_hold = exp_q.pop_front();
                check("read_data", int'(bus_data_out), int'(m_hold));
            end
        end else begin
            if (exp_q.size() != 0) begin
                check("read_missing", 0, 1);
                m_hold = exp_q.pop_front();
            end
            check("data_hold", int'(bus_data_out), int'(m_hold));
        end
    end

    initial begin
        int pulses;
        int saved;
        bit w, r, clr;
        logic [23:0] a;
        logic [7:0]  d;
        reset = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = 24'h0; bus_data_in = 8'h0;

        applyStimulus(1, 0, 0, 24'h0, 8'h0);
        applyStimulus(1, 0, 0, 24'h0, 8'h0);
        check("reset_valid", int'(bus_data_valid), 0);
        check("reset_data", int'(bus_data_out), 0);

        $display("[TB] enable and count to 8");
        applyStimulus(0, 1, 0, CTRL, 8'h01);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            pulses += int'(irq_32hz);
        end
        check("t1_timer", int'(timer), 8);
        check("t1_irq32_pulses", pulses, 1);

        $display("[TB] wrap 255 to 0");
        waitTick(255);
        idle(1);
        check("wrap_irqs", int'({irq_1hz, irq_2hz, irq_8hz, irq_32hz}), 4'hF);
        check("wrap_timer", int'(timer), 0);

        $display("[TB] clear on tick edge");
        waitTick(8'h25);
        applyStimulus(0, 1, 0, CTRL, 8'h03);
        check("clr_timer", int'(timer), 0);
        check("clr_irq", int'({irq_1hz, irq_2hz, irq_8hz, irq_32hz}), 0);
        applyStimulus(0, 0, 1, CTRL, 8'h00);
        check("clr_ctrl_read", int'(bus_data_out), 1);
        idle(P - 2);
        check("clr_prescale_hold", int'(timer), 0);
        idle(1);
        check("clr_prescale_tick", int'(timer), 1);

        $display("[TB] disable mid-prescale");
        idle(2);
        applyStimulus(0, 1, 0, CTRL, 8'h00);
        saved = int'(timer);
        idle(100);
        check("dis_timer", int'(timer), saved);
        applyStimulus(0, 1, 0, CTRL, 8'h01);
        idle(P);

        $display("[TB] read on increment edge");
        waitTick(8'h10);
        applyStimulus(0, 0, 1, CNT, 8'h00);
        check("rd_edge_data", int'(bus_data_out), 8'h10);
        check("rd_edge_valid", int'(bus_data_valid), 1);
        applyStimulus(0, 0, 1, BAD, 8'h00);
        check("rd_bad_valid", int'(bus_data_valid), 0);
        applyStimulus(0, 1, 1, CTRL, 8'h00);
        check("rd_wr_same_cycle", int'(bus_data_out), 1);
        applyStimulus(0, 1, 0, CTRL, 8'h01);

        $display("[TB] reset with irq pending");
        waitTick(8'h7F);
        applyStimulus(1, 0, 0, 24'h0, 8'h0);
        check("rst_outputs", int'({timer, bus_data_valid, irq_1hz, irq_2hz, irq_8hz, irq_32hz}), 0);
        idle(1);
        check("rst_no_irq", int'({irq_1hz, irq_2hz, irq_8hz, irq_32hz}), 0);

        $display("[TB] random traffic");
        applyStimulus(0, 1, 0, CTRL, 8'h01);
        for (int i = 0; i < 1500; i++) begin
            w   = ($urandom_range(0, 7) == 0);
            r   = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       a = CTRL;
                1:       a = CNT;
                2:       a = BAD;
                default: a = CNT;
            endcase
            d = 8'($urandom_range(0, 255));
            d[1] = clr;
            if (a == CTRL && w && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            applyStimulus($urandom_range(0, 299) == 0, w, r, a, d);
        end

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
